// File: rtl/cache_axi_bridge.sv
// Bridges cache line-refill/write-back requests onto AXI3 with independent read and write FSMs.
// The victim line is buffered internally so the cache is released as soon as the write is accepted.
module cache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    output logic         rd_rdy,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         ret_valid,
    output logic [1:0]   ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    output logic         wr_rdy,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wstate_t;

    rstate_t        rstate_q, rstate_d;
    wstate_t        wstate_q, wstate_d;
    logic [31:0]    raddr_q, raddr_d;
    logic [2:0]     rtype_q, rtype_d;
    logic [31:0]    waddr_q, waddr_d;
    logic [2:0]     wtype_q, wtype_d;
    logic [3:0]     wmask_q, wmask_d;
    logic [127:0]   wbuf_q, wbuf_d;
    logic [1:0]     wcnt_q, wcnt_d;
    logic           rd_fire, wr_fire, rd_hazard;

    function automatic logic [7:0] burst_len(input logic [2:0] t);
        return (t == 3'b100) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] burst_size(input logic [2:0] t);
        return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q <= R_IDLE;
            wstate_q <= W_IDLE;
            wcnt_q   <= '0;
        end else begin
            rstate_q <= rstate_d;
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
        end
        raddr_q <= raddr_d;
        rtype_q <= rtype_d;
        waddr_q <= waddr_d;
        wtype_q <= wtype_d;
        wmask_q <= wmask_d;
        wbuf_q  <= wbuf_d;
    end

    // A read may not overtake a write-back of the same line, including one accepted this cycle.
    always_comb begin
        wr_rdy    = ~reset & (wstate_q == W_IDLE);
        wr_fire   = wr_req & wr_rdy;
        rd_hazard = ((wstate_q != W_IDLE) && (rd_addr[31:4] == waddr_q[31:4]))
                  || (wr_fire && (rd_addr[31:4] == wr_addr[31:4]));
        rd_rdy    = ~reset & (rstate_q == R_IDLE) & ~rd_hazard;
        rd_fire   = rd_req & rd_rdy;
    end

    always_comb begin
        rstate_d  = rstate_q;
        raddr_d   = raddr_q;
        rtype_d   = rtype_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        arid      = RD_ID;
        araddr    = raddr_q;
        arlen     = burst_len(rtype_q);
        arsize    = burst_size(rtype_q);
        case (rstate_q)
            R_IDLE: begin
                if (rd_fire) begin
                    raddr_d  = rd_addr;
                    rtype_d  = rd_type;
                    rstate_d = R_AR;
                end
            end
            R_AR: begin
                arvalid = ~reset;
                if (arready) rstate_d = R_DATA;
            end
            R_DATA: begin
                rready = ~reset;
                if (rvalid && rlast) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
        ret_valid = rvalid & rready;
        ret_last  = {1'b0, rlast & ret_valid};
        ret_data  = rdata;
    end

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wtype_d  = wtype_q;
        wmask_d  = wmask_q;
        wbuf_d   = wbuf_q;
        wcnt_d   = wcnt_q;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        awid     = WR_ID;
        awaddr   = waddr_q;
        awlen    = burst_len(wtype_q);
        awsize   = burst_size(wtype_q);
        wdata    = wbuf_q[{wcnt_q, 5'd0} +: 32];
        wstrb    = (wtype_q == 3'b100) ? 4'hf : wmask_q;
        wlast    = (wcnt_q == awlen[1:0]);
        case (wstate_q)
            W_IDLE: begin
                if (wr_fire) begin
                    waddr_d  = wr_addr;
                    wtype_d  = wr_type;
                    wmask_d  = wr_wstrb;
                    wbuf_d   = wr_data;
                    wcnt_d   = '0;
                    wstate_d = W_AW;
                end
            end
            W_AW: begin
                awvalid = ~reset;
                if (awready) wstate_d = W_DATA;
            end
            W_DATA: begin
                wvalid = ~reset;
                if (wready) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wlast) wstate_d = W_B;
                end
            end
            W_B: begin
                bready = ~reset;
                if (bvalid) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

endmodule
